// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared types and encodings for the LSU bus controller.
package lsu_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned TIMEOUT_DEF = 255;

  // Illegal size counts as misaligned so both take the same error path.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_lane_align.sv
// Byte-lane steering: store data/enables out to the bus, load data back with extension.
module lsu_lane_align
  import lsu_bus_ctrl_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o
);

  logic [31:0] mask;
  logic [3:0]  be_base;
  logic [4:0]  sh;
  logic [31:0] rsh;

  always_comb begin
    mask    = 32'hFFFF_FFFF;
    be_base = 4'b1111;
    case (size_i)
      SZ_B: begin mask = 32'h0000_00FF; be_base = 4'b0001; end
      SZ_H: begin mask = 32'h0000_FFFF; be_base = 4'b0011; end
      default: ;
    endcase
    sh      = {off_i, 3'b000};
    be_o    = be_base << off_i;
    wlane_o = (wdata_i & mask) << sh;
    rsh     = (rword_i >> sh) & mask;
    rdata_o = rsh;
    if (sext_i) begin
      case (size_i)
        SZ_B:    rdata_o = {{24{rsh[7]}}, rsh[7:0]};
        SZ_H:    rdata_o = {{16{rsh[15]}}, rsh[15:0]};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Single-outstanding load/store bus controller with alignment checks and an ack timeout.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  mem_size,
  input  logic [2:0]  mem_extend,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [29:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  off_q, size_q;
  logic        sext_q;
  logic        rsp_valid_q, rsp_err_q, bus_rd_q, bus_wr_q;
  logic [31:0] rsp_rdata_q, bus_wdata_q;
  logic [29:0] bus_addr_q;
  logic [3:0]  bus_be_q;

  logic        idle;
  logic [1:0]  al_off, al_size;
  logic        al_sext;
  logic [3:0]  al_be;
  logic [31:0] al_wlane, al_rdata;
  logic        unused_ext;

  assign unused_ext = ^mem_extend[1:0];
  assign idle       = (state_q == IDLE);

  // One aligner serves both directions: request fields while idle, latched fields afterwards.
  assign al_off  = idle ? req_addr[1:0]  : off_q;
  assign al_size = idle ? mem_size       : size_q;
  assign al_sext = idle ? ~mem_extend[2] : sext_q;

  lsu_lane_align u_align (
    .off_i   (al_off),
    .size_i  (al_size),
    .sext_i  (al_sext),
    .wdata_i (req_wdata),
    .rword_i (bus_rdata),
    .be_o    (al_be),
    .wlane_o (al_wlane),
    .rdata_o (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      bus_addr_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          off_q  <= req_addr[1:0];
          size_q <= mem_size;
          sext_q <= ~mem_extend[2];
          if (misaligned(mem_size, req_addr[1:0])) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            state_q     <= req_we ? WR_WAIT : RD_WAIT;
            cnt_q       <= '0;
            bus_addr_q  <= req_addr[31:2];
            bus_be_q    <= al_be;
            bus_wdata_q <= req_we ? al_wlane : 32'h0;
            bus_rd_q    <= ~req_we;
            bus_wr_q    <= req_we;
          end
        end
        RD_WAIT, WR_WAIT: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (bus_ack) begin
            state_q     <= RESP;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= (state_q == RD_WAIT) ? al_rdata : 32'h0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= RESP;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_rd    = bus_rd_q;
  assign bus_wr    = bus_wr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule
